// File: rtl/elastic_pipe_regs.sv
// Chain of DEPTH valid/ready stage registers with bubble collapsing and per-stage flush.
// Stage 0 faces the producer, stage DEPTH-1 drives the consumer.
module elastic_pipe_regs #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             in_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH-1:0]             out_data_o,
    input  logic [DEPTH-1:0]             flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            ev;
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH:0]              rdy;
    logic [CW-1:0]               occ_q, occ_d;

    // A flushed entry behaves as a bubble for this cycle.
    assign ev = valid_q & ~flush_i;

    always_comb begin
        rdy        = '0;
        rdy[DEPTH] = out_ready_i;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy[i] = ~ev[i] | rdy[i+1];
        end
    end

    // Payload only moves with a live upstream entry, so bubbles never toggle data_q.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (rdy[0]) begin
            valid_d[0] = in_valid_i;
            if (in_valid_i) begin
                data_d[0] = in_data_i;
            end
        end
        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
                valid_d[i] = ev[i-1];
                if (ev[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + CW'(valid_d[i]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            data_q  <= '0;
            occ_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            occ_q   <= occ_d;
        end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = ev[DEPTH-1];
    assign out_data_o  = data_q[DEPTH-1];
    assign occupancy_o = occ_q;

endmodule
